// File: rtl/srrc_tx_interp.sv
// srrc_tx_interp: transmit pulse-shaping interpolator, 4x, 32-tap polyphase FIR.
// One symbol is accepted every 4 clocks and one shaped 1s17 sample is produced per clock.
module srrc_tx_interp (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] sym_in,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic        coef_we,
    input  logic [4:0]  coef_addr,
    input  logic [17:0] coef_data,
    output logic [17:0] out,
    output logic [1:0]  out_phase,
    output logic        out_valid,
    output logic        underflow
);

    logic        [1:0]  p;
    logic signed [17:0] x [8];
    logic signed [17:0] h [32];
    logic               accepted;
    logic signed [35:0] prod;
    logic        [4:0]  idx;
    logic signed [38:0] acc;
    logic signed [38:0] acc_sh;
    logic        [17:0] sat;

    assign sym_ready = (p == 2'd3);

    // Free-running polyphase index.
    always_ff @(posedge clk) begin
        if (reset) p <= '0;
        else       p <= p + 2'd1;
    end

    // Symbol delay line, shifts on the symbol-accept cycle; empty slots are zero-stuffed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < 8; k++) x[k] <= '0;
        end else if (sym_ready) begin
            for (int unsigned k = 1; k < 8; k++) x[k] <= x[k-1];
            x[0] <= sym_valid ? sym_in : '0;
        end
    end

    // Run-time coefficient store; writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned n = 0; n < 32; n++) h[n] <= '0;
        end else if (coef_we) begin
            h[coef_addr] <= coef_data;
        end
    end

    // Phase-p dot product over the 8 delay-line taps, h index 4k+p.
    always_comb begin
        acc  = '0;
        prod = '0;
        idx  = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx  = {k[2:0], p};
            prod = x[k] * h[idx];
            acc  = acc + {{3{prod[35]}}, prod};
        end
    end

    // Floor to 1s17 and clamp: in range exactly when acc[38:34] agree.
    always_comb begin
        acc_sh = acc >>> 17;
        if (acc_sh[38:17] == {22{acc_sh[38]}})
            sat = acc_sh[17:0];
        else
            sat = acc_sh[38] ? 18'h20000 : 18'h1FFFF;
    end

    // Registered sample and its phase tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_phase <= '0;
        end else begin
            out       <= sat;
            out_phase <= p;
        end
    end

    // Sticky status: out_valid trails the first accepted symbol by one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            accepted  <= 1'b0;
            out_valid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= out_valid | accepted;
            if (sym_ready) begin
                if (sym_valid) accepted  <= 1'b1;
                else           underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_srrc_tx_interp.sv
// Testbench for srrc_tx_interp: driver pushes expected responses from an arithmetic
// reference model into a queue; a monitor pops and compares after every clock edge.
module tb_srrc_tx_interp;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] sym_in;
    logic        sym_valid;
    logic        sym_ready;
    logic        coef_we;
    logic [4:0]  coef_addr;
    logic [17:0] coef_data;
    logic [17:0] dout;
    logic [1:0]  out_phase;
    logic        out_valid;
    logic        underflow;

    srrc_tx_interp dut (
        .clk(clk), .reset(reset),
        .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out(dout), .out_phase(out_phase), .out_valid(out_valid), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int o;
        int ph;
        int v;
        int u;
        int r;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done  = 0;

    // Reference model: symbol history (newest first), coefficients, cycle bookkeeping.
    int hist [8];
    int hm   [32];
    int mp;
    bit seen_sym;
    bit uf_m;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int shaped(input int ph);
        longint acc = 0;
        longint v;
        for (int k = 0; k < 8; k++) acc += longint'(hist[k]) * longint'(hm[4*k + ph]);
        v = acc >>> 17;
        if (v > 131071)  v = 131071;
        if (v < -131072) v = -131072;
        return int'(v);
    endfunction

    // One clock: drive inputs, predict the post-edge outputs, advance the model.
    task automatic step(input bit rst, input bit sv, input int sym,
                        input bit we, input int addr, input int data);
        exp_t e;
        reset     = rst;
        sym_valid = sv;
        sym_in    = 18'(sym);
        coef_we   = we;
        coef_addr = 5'(addr);
        coef_data = 18'(data);
        if (rst) begin
            e = '{o: 0, ph: 0, v: 0, u: 0, r: 0};
            for (int k = 0; k < 8; k++)  hist[k] = 0;
            for (int n = 0; n < 32; n++) hm[n] = 0;
            mp = 0; seen_sym = 0; uf_m = 0;
        end else begin
            e.o  = shaped(mp);
            e.ph = mp;
            e.v  = seen_sym;
            if (mp == 3) begin
                for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = sv ? sym : 0;
                if (sv) seen_sym = 1;
                else    uf_m = 1;
            end
            e.u = uf_m;
            if (we) hm[addr] = data;
            mp   = (mp + 1) % 4;
            e.r  = (mp == 3);
        end
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input int sym);
        for (int i = 0; i < n; i++) step(0, 1, sym, 0, 0, 0);
    endtask

    task automatic write_coef(input int addr, input int data);
        step(0, 1, 0, 1, addr, data);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic align_to_slot();
        while (mp != 3) step(0, 1, 0, 0, 0, 0);
    endtask

    function automatic int rnd18();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out",       int'($signed(dout)), e.o);
                chk("out_phase", int'(out_phase),     e.ph);
                chk("out_valid", int'(out_valid),     e.v);
                chk("underflow", int'(underflow),     e.u);
                chk("sym_ready", int'(sym_ready),     e.r);
            end
        end
    end

    initial begin
        int mark;
        // Reset values.
        do_reset(5);

        // Impulse response with h[n] = 1000n - 16000.
        for (int n = 0; n < 32; n++) write_coef(n, 1000*n - 16000);
        align_to_slot();
        step(0, 1, -131072, 0, 0, 0);
        idle(40, 0);

        // Underflow: one empty slot, then normal traffic.
        align_to_slot();
        step(0, 0, 0, 0, 0, 0);
        idle(12, 0);

        // Randomised streaming with occasional live coefficient writes and empty slots.
        for (int i = 0; i < 300; i++)
            step(0, ($urandom_range(0, 7) != 0), rnd18(),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 31)), rnd18());

        // Reset clears the sticky flag.
        do_reset(2);
        idle(8, 0);

        // Saturation, negative then positive.
        for (int k = 0; k < 8; k++) write_coef(4*k, 131071);
        idle(48, -131072);
        idle(48, 131071);

        // Live coefficient update on h[0].
        do_reset(2);
        write_coef(0, 4000);
        idle(30, -131072);
        step(0, 1, -131072, 1, 0, -2000);
        idle(20, -131072);

        // Reset mid-stream, then symbols without reloaded coefficients.
        do_reset(1);
        idle(24, 131071);
        for (int n = 0; n < 32; n++) write_coef(n, rnd18());
        mark = 0;
        while (mark < 100) begin
            step(0, 1, rnd18(), 0, 0, 0);
            mark++;
        end

        done = 1;
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/srrc_tx_interp.md
# srrc_tx_interp

Transmit-side pulse-shaping interpolator for the modem. It accepts one 1s17 symbol every 4 clocks from the symbol mapper. It produces one shaped 1s17 sample per clock using a 32-tap, 4-phase polyphase FIR. The coefficients are loaded at run time through a write port. It is the transmit counterpart of the receive matched filter and feeds the DAC/channel path.

## Interface
Parameters: none. The following are fixed:
- Interpolation factor: 4.
- Tap count: 32, organised as 4 phases × 8 taps.
- Data width and coefficient width: 18 bits.

Ports:
- `clk`  in  1  system clock. All state is updated on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sym_in`  in  18  signed 1s17 symbol. Sampled when `sym_ready` is high.
- `sym_valid`  in  1  `sym_in` is valid. Sampled when `sym_ready` is high.
- `sym_ready`  out  1  high for one cycle in 4. This is the symbol-accept cycle.
- `coef_we`  in  1  coefficient write enable.
- `coef_addr`  in  5  coefficient index n, where n = 0..31.
- `coef_data`  in  18  signed 1s17 coefficient h[n].
- `out`  out  18  signed 1s17 shaped sample, registered.
- `out_phase`  out  2  polyphase index p of the sample currently on `out`.
- `out_valid`  out  1  high once the first valid symbol has been accepted.
- `underflow`  out  1  sticky flag: a symbol slot passed with `sym_valid` low.

## Operation
- **Phase counter p** (2 bits): free-running 0→1→2→3→0. It increments every cycle.
  - `sym_ready` = (p == 3).
- **Symbol delay line x[0..7]** (18 bits each):
  - At the edge ending a cycle with `sym_ready` high, the line shifts: x[k] ← x[k-1].
  - x[0] ← `sym_in` if `sym_valid` is high, otherwise 0 (zero-stuffed).
- **Coefficient store h[0..31]**:
  - `coef_we` high writes `coef_data` into h[`coef_addr`] at the edge.
  - The new value is used from the next cycle onward.
  - Writes are permitted while the block is streaming. There is no stall, and mixed old/new coefficients are acceptable for that transient.
- **Per-cycle computation**:
  - acc = Σ_{k=0..7} x[k]·h[4k+p], accumulated as a signed 39-bit sum of 36-bit products.
  - Registered outputs: `out` ← sat18(acc[38:17]); `out_phase` ← p.
- **Width rule**:
  - The result is acc[34:17] when acc[38:34] are all equal.
  - Otherwise it clamps to +131071 if acc[38]=0, or −131072 if acc[38]=1.
  - Truncation (floor), no rounding.
- **`underflow`**: set at the edge ending a cycle with `sym_ready` high and `sym_valid` low. It is cleared only by `reset`.
- **`out_valid`**: set at the edge following the edge at which the first symbol with `sym_valid` high is accepted. It stays high until `reset`.
- **Reset** (including mid-stream):
  - Cleared to 0: p, all x[k], all h[n], `out`, `out_phase`, `out_valid`, `underflow`.
  - `coef_we` is ignored while `reset` is high.
  - Coefficients must be reloaded after every reset.

## Timing
- **Reset release**: the cycle after `reset` falls has p=0. `sym_ready` is first high in the 4th cycle after release, then every 4th cycle.
- **Symbol latency**: a symbol accepted at edge A is in x[0] during cycles A..A+3 (p = 0..3). Its h[0..3] contributions appear on `out` after edges A+1..A+4.
  - Its h[4k+p] contribution appears 4k cycles later.
  - The full 32-sample impulse response spans edges A+1..A+32.
- **Output phase**: `out_phase` after edge A+1 is 0.
- **Simultaneous events**:
  - A coefficient write and a symbol shift at the same edge both take effect. The next sample uses the new x and the new h.
  - A write to h[n] in the same cycle as `reset` is discarded.
- **Back-to-back symbols**: one symbol every 4 cycles is the maximum and only rate. There is no backpressure beyond `sym_ready`.

## Test plan
- **Reset values**: hold `reset` 5 cycles, then release.
  - During reset: `out`=0, `out_valid`=0, `underflow`=0, `sym_ready`=0.
  - `sym_ready` is first high in cycle 4 after release, with period 4.
- **Impulse response**:
  - Load h[n] = 1000·n − 16000.
  - Send one symbol −131072 with `sym_valid`, then symbols of 0.
  - `out` after edges A+1..A+32 equals −h[0..31] exactly (16000, 15000, …, −15000), with `out_phase` cycling 0,1,2,3.
  - `out` is 0 otherwise.
- **Underflow**: after loading coefficients, keep `sym_valid` low on one `sym_ready` cycle.
  - `underflow` rises at that edge and stays high.
  - The slot contributes 0 to `out`.
  - `reset` clears the flag.
- **Saturation**:
  - Set h[0,4,…,28] = 131071 and all other taps to 0.
  - Feed 8+ consecutive symbols of −131072.
  - Phase-0 samples clamp to −131072; other phases are 0.
  - Repeat with symbols of +131071: phase-0 samples clamp to +131071.
- **Live coefficient update**:
  - Stream constant symbols of −131072 with only h[0]=4000 nonzero.
  - Write h[0]=−2000 mid-stream.
  - Phase-0 samples change from −4000 to 2000 starting with the first phase-0 cycle after the write edge.
- **Reset mid-stream**: assert `reset` during a response.
  - The next cycle shows `out`=0.
  - After release, `out` stays 0 even with symbols applied, until coefficients are reloaded.
